// File: rtl/laser_on_control_multi.sv
// rtl/laser_on_control_multi.sv - UART byte command decoder driving NUM_CH active-low laser enables
// Optional build macro LASER_INTERLOCK_EN adds the interlock_ok input.
module laser_on_control_multi #(
    parameter int          NUM_CH         = 4,
    parameter logic [7:0]  ON_CODE        = 8'hB1,
    parameter logic [7:0]  OFF_CODE       = 8'hAA,
    parameter logic [7:0]  ALL_OFF_CODE   = 8'hA0,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        data_out_1_byte,
    input  logic              data_out_en_1_byte,
`ifdef LASER_INTERLOCK_EN
    input  logic              interlock_ok,
`endif
    output logic [NUM_CH-1:0] laser_on_n,
    output logic              cmd_err,
    output logic              wdt_trip
);

    typedef enum logic {IDLE, WAIT_CH} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              op_on;
    logic              op_on_nxt;
    logic [NUM_CH-1:0] laser_nxt;
    logic              err_nxt;
    logic              wdt_fire;
    logic              ilk_ok;
    logic [31:0]       byte_ext;
    logic              ch_valid;

`ifdef LASER_INTERLOCK_EN
    assign ilk_ok = interlock_ok;
`else
    assign ilk_ok = 1'b1;
`endif

    assign byte_ext = {24'b0, data_out_1_byte};
    assign ch_valid = (byte_ext < 32'(NUM_CH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_on      <= 1'b0;
            laser_on_n <= '1;
            cmd_err    <= 1'b0;
            wdt_trip   <= 1'b0;
        end else begin
            state      <= state_nxt;
            op_on      <= op_on_nxt;
            laser_on_n <= laser_nxt;
            cmd_err    <= err_nxt;
            wdt_trip   <= wdt_fire;
        end
    end

    always_comb begin
        state_nxt = state;
        op_on_nxt = op_on;
        if (wdt_fire) begin
            state_nxt = IDLE;
        end else if (data_out_en_1_byte) begin
            case (state)
                IDLE: begin
                    if (data_out_1_byte == ON_CODE) begin
                        state_nxt = WAIT_CH;
                        op_on_nxt = 1'b1;
                    end else if (data_out_1_byte == OFF_CODE) begin
                        state_nxt = WAIT_CH;
                        op_on_nxt = 1'b0;
                    end
                end
                WAIT_CH: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; the watchdog trip overrides any command.
    always_comb begin
        laser_nxt = laser_on_n;
        err_nxt   = 1'b0;
        if (wdt_fire) begin
            laser_nxt = '1;
        end else if (data_out_en_1_byte) begin
            case (state)
                IDLE: begin
                    if (data_out_1_byte == ALL_OFF_CODE)
                        laser_nxt = '1;
                end
                WAIT_CH: begin
                    if (data_out_1_byte == ALL_OFF_CODE) begin
                        laser_nxt = '1;
                    end else if (!ch_valid) begin
                        err_nxt = 1'b1;
                    end else if (op_on && !ilk_ok) begin
                        err_nxt = 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (byte_ext == 32'(i))
                                laser_nxt[i] = !op_on;
                        end
                    end
                end
                default: laser_nxt = laser_on_n;
            endcase
        end
        if (!ilk_ok)
            laser_nxt = '1;
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdt
            localparam int         CW       = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] TRIP_VAL = CW'(TIMEOUT_CYCLES - 1);
            logic [CW-1:0] wdt_cnt;
            logic          any_on;

            assign any_on   = (laser_on_n != '1);
            assign wdt_fire = !data_out_en_1_byte && any_on && (wdt_cnt == TRIP_VAL);

            always_ff @(posedge clk) begin
                if (rst)
                    wdt_cnt <= '0;
                else if (data_out_en_1_byte || wdt_fire || !any_on)
                    wdt_cnt <= '0;
                else
                    wdt_cnt <= wdt_cnt + CW'(1);
            end
        end else begin : g_no_wdt
            assign wdt_fire = 1'b0;
        end
    endgenerate

endmodule

// File: doc/laser_on_control_multi.md
Name: laser_on_control_multi

Overview:
- Multi-channel successor to the single-laser on/off controller.
- Decodes the 1-byte UART command stream into per-channel active-low laser enables.
- Generalised to NUM_CH channels with a 2-byte addressed command set, a single-byte all-off command, a keepalive watchdog and an error flag.
- Sits between the UART byte receiver and the laser driver pins.

Parameters:
- NUM_CH, 4, number of laser channels (1..32).
- ON_CODE, 8'hB1, opcode: turn addressed channel on.
- OFF_CODE, 8'hAA, opcode: turn addressed channel off.
- ALL_OFF_CODE, 8'hA0, single-byte opcode: all channels off.
- TIMEOUT_CYCLES, 50_000_000, keepalive limit in clk cycles; 0 disables the watchdog.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- data_out_1_byte  input  8  received command byte
- data_out_en_1_byte  input  1  1-cycle strobe: data_out_1_byte valid
- laser_on_n  output  NUM_CH  per-channel enable, active-low, registered
- cmd_err  output  1  1-cycle pulse: bad channel index or rejected command
- wdt_trip  output  1  1-cycle pulse: watchdog forced all channels off

Behaviour:
- Single clock domain. Reset is synchronous, active-high.
- Reset values: laser_on_n = all 1s; cmd_err = 0; wdt_trip = 0; parser = IDLE; watchdog counter = 0.
- Parser FSM, states IDLE and WAIT_CH. Only bytes with the strobe high are considered.
- IDLE:
  - ON_CODE or OFF_CODE: latch the opcode, go to WAIT_CH.
  - ALL_OFF_CODE: laser_on_n <= all 1s, stay in IDLE.
  - Any other byte: ignored, no error.
- WAIT_CH:
  - ALL_OFF_CODE has priority: all off, go to IDLE.
  - Byte < NUM_CH: that channel bit <= 0 for ON or 1 for OFF, go to IDLE.
  - Otherwise: cmd_err pulses, no output change, go to IDLE.
- WAIT_CH waits indefinitely for a byte; only the watchdog or reset aborts it.
- Latency: laser_on_n updates on the same rising edge that samples the channel byte (or the ALL_OFF byte). Visible one cycle after the strobe.
- Redundant commands (ON to a channel already on, OFF to one already off) are legal, with no error and no change.
- Watchdog counter, width $clog2(TIMEOUT_CYCLES+1):
  - Cleared on any strobe.
  - Otherwise increments while any laser_on_n bit is 0.
  - Held at 0 while all channels are off.
- Trip condition: counter == TIMEOUT_CYCLES-1, no strobe this cycle, at least one channel on.
- On the trip edge: laser_on_n <= all 1s, parser -> IDLE, counter -> 0, wdt_trip = 1 for one cycle.
- A strobe in the would-be trip cycle prevents the trip; that byte is processed normally.
- TIMEOUT_CYCLES == 0: the counter and trip logic are not generated; wdt_trip is tied to 0.
- Reset mid-command (in WAIT_CH) discards the pending opcode. The next byte is parsed from IDLE.
- All outputs are driven from flops; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: LASER_INTERLOCK_EN.
- Defined: adds port interlock_ok (input, 1, active-high, already synchronised to clk).
  - While interlock_ok = 0, laser_on_n is forced to all 1s, starting the cycle after it drops.
  - A completed ON command while interlock_ok = 0 is rejected: channel stays off, cmd_err pulses.
  - OFF and ALL_OFF commands are accepted normally.
  - Channels do not re-enable automatically when interlock_ok returns to 1; a new ON command is required.
- Not defined: the port does not exist and behaviour is as above.

Test Plan:
- Reset, then bytes B1,02 → laser_on_n = 4'b1011 one cycle after the 02 strobe; cmd_err stays 0.
- From 4'b1011, bytes AA,02 → 4'b1111. Then B1,07 (7 ≥ NUM_CH) → cmd_err pulses once; outputs stay 4'b1111.
- B1,00 then B1,03, giving 4'b0110. Then byte A0 → 4'b1111 the next cycle. B1 followed by A0 → all off, parser in IDLE, no cmd_err.
- TIMEOUT_CYCLES = 100. B1,01, then no strobes → exactly 100 cycles after the 01 strobe, wdt_trip pulses once and laser_on_n = 4'b1111. Repeat with an ignored byte 55 every 50 cycles → no trip.
- Assert rst between B1 and the channel byte, then send 01 → no channel turns on. Then B1,01 → channel 1 turns on normally.
- LASER_INTERLOCK_EN defined:
  - interlock_ok = 0, then B1,00 → cmd_err pulses, output stays 4'b1111.
  - With channel 0 on, drop interlock_ok → all off the next cycle; raising it again leaves channels off.
